// File: rtl/fou_it2_tdm_fuzzifier.sv
// Interval type-2 trapezoidal fuzzifier with a time-multiplexed serial divider.
//
// N_IN crisp inputs each have N_MF fuzzy sets. Every set has an upper and a lower trapezoid.
// Trapezoid k = 2*(i*N_MF+m) + L uses L=0 for the upper trapezoid and L=1 for the lower one.
// All 2*N_IN*N_MF trapezoids are evaluated one after another by a single restoring divider.
// Each trapezoid takes W+2 cycles: LOAD, W cycles of DIV, then STORE.
//
// Ports:
//   CLK, RESET      clock and synchronous active-high reset
//   Input_flat      crisp inputs; input i at [i*W +: W]
//   EN_Entrada_FOU  start request; accepted only when idle
//   cfg_we/addr/data corner write; addr = {k, c}, c: 0=A 1=B 2=C 3=D; idle only
//   busy            high from start acceptance through the done cycle
//   done            one-cycle pulse; results valid from this cycle on
//   FOU_UP/FOU_LOW  upper/lower grades; set j=i*N_MF+m at [j*W +: W]
//   Ativo_UP        bit (N_IN*N_MF-1-j) set iff upper grade j is non-zero
module fou_it2_tdm_fuzzifier #(
    parameter int unsigned W    = 8,
    parameter int unsigned N_IN = 2,
    parameter int unsigned N_MF = 3
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [N_IN*W-1:0]                Input_flat,
    input  logic                             EN_Entrada_FOU,
    input  logic                             cfg_we,
    input  logic [$clog2(2*N_IN*N_MF)+1:0]   cfg_addr,
    input  logic [W-1:0]                     cfg_data,
    output logic                             busy,
    output logic                             done,
    output logic [N_IN*N_MF*W-1:0]           FOU_UP,
    output logic [N_IN*N_MF*W-1:0]           FOU_LOW,
    output logic [N_IN*N_MF-1:0]             Ativo_UP
);

    localparam int unsigned NS = N_IN * N_MF;
    localparam int unsigned K  = 2 * NS;
    localparam int unsigned KW = $clog2(K);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [KW-1:0] KLast   = KW'(K - 1);
    localparam logic [CW-1:0] CntLast = CW'(W - 1);
    localparam logic [W-1:0]  MaxVal  = '1;

    typedef enum logic [2:0] {StIdle, StLoad, StDiv, StStore, StDone} state_e;

    state_e              state_q;
    logic [KW-1:0]       k_q;
    logic [CW-1:0]       cnt_q;
    logic [N_IN*W-1:0]   in_q;
    logic [W-1:0]        corner_q [K][4];

    // Divider datapath: rem_q is the running remainder, num_q holds the dividend
    // bits not yet shifted in, quo_q collects quotient bits MSB first.
    logic [W-1:0]        rem_q, num_q, den_q, quo_q;
    logic                force_q;
    logic [W-1:0]        force_val_q;

    logic [NS*W-1:0]     up_sh_q, low_sh_q;

    // Corner register file
    logic [KW-1:0]       cfg_k;
    logic [1:0]          cfg_c;

    assign cfg_k = cfg_addr[KW+1:2];
    assign cfg_c = cfg_addr[1:0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            corner_q <= '{default: '0};
        end else if (cfg_we && (state_q == StIdle) && (cfg_k <= KLast)) begin
            corner_q[cfg_k][cfg_c] <= cfg_data;
        end
    end

    // Classification of the current trapezoid
    int unsigned         slot;
    logic [W-1:0]        x, ca, cb, cc, cd;
    logic [W-1:0]        n, dn;
    logic [2*W-1:0]      numer;
    logic                plateau, zero;

    always_comb begin
        slot = 32'(k_q >> 1);
        x    = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            for (int unsigned m = 0; m < N_MF; m++) begin
                if (slot == i * N_MF + m) x = in_q[i*W +: W];
            end
        end
        ca = corner_q[k_q][0];
        cb = corner_q[k_q][1];
        cc = corner_q[k_q][2];
        cd = corner_q[k_q][3];

        plateau = (x >= cb) && (x <= cc);
        zero    = (x <= ca) || (x >= cd);
        if (x < cb) begin
            n  = x - ca;
            dn = cb - ca;
        end else begin
            n  = cd - x;
            dn = cd - cc;
        end
        // n * MAX as (n << W) - n
        numer = {n, {W{1'b0}}} - {{W{1'b0}}, n};
    end

    // One restoring-division step
    logic [W:0]          rem_sh;
    logic                ge;
    logic [W-1:0]        rem_nx;

    always_comb begin
        rem_sh = {rem_q, num_q[W-1]};
        ge     = rem_sh >= {1'b0, den_q};
        rem_nx = ge ? W'(rem_sh - {1'b0, den_q}) : rem_sh[W-1:0];
    end

    // Shadow contents with the current grade merged in, so the final STORE can publish
    // a complete result set on the same edge that raises done.
    logic [W-1:0]        grade;
    logic [NS*W-1:0]     up_nx, low_nx;
    logic [NS-1:0]       ativo_nx;

    always_comb begin
        grade  = force_q ? force_val_q : quo_q;
        up_nx  = up_sh_q;
        low_nx = low_sh_q;
        if (k_q[0]) low_nx[slot*W +: W] = grade;
        else        up_nx[slot*W +: W]  = grade;
        ativo_nx = '0;
        for (int unsigned j = 0; j < NS; j++) begin
            ativo_nx[NS-1-j] = |up_nx[j*W +: W];
        end
    end

    // Sequencer
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            FOU_UP      <= '0;
            FOU_LOW     <= '0;
            Ativo_UP    <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            in_q        <= '0;
            rem_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            force_q     <= 1'b0;
            force_val_q <= '0;
            up_sh_q     <= '0;
            low_sh_q    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (EN_Entrada_FOU) begin
                        in_q    <= Input_flat;
                        k_q     <= '0;
                        busy    <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    // Plateau/zero bypass the quotient but still spend W divide cycles.
                    force_q     <= plateau || zero;
                    force_val_q <= plateau ? MaxVal : '0;
                    if (plateau || zero) begin
                        rem_q <= '0;
                        num_q <= '0;
                        den_q <= W'(1);
                    end else begin
                        rem_q <= numer[2*W-1:W];
                        num_q <= numer[W-1:0];
                        den_q <= dn;
                    end
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= StDiv;
                end
                StDiv: begin
                    rem_q <= rem_nx;
                    num_q <= num_q << 1;
                    quo_q <= {quo_q[W-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) state_q <= StStore;
                end
                StStore: begin
                    up_sh_q  <= up_nx;
                    low_sh_q <= low_nx;
                    if (k_q == KLast) begin
                        FOU_UP   <= up_nx;
                        FOU_LOW  <= low_nx;
                        Ativo_UP <= ativo_nx;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= StLoad;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fou_it2_tdm_fuzzifier.sv
module tb_fou_it2_tdm_fuzzifier;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] Input_flat;
    logic        EN_Entrada_FOU;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        busy;
    logic        done;
    logic [47:0] FOU_UP;
    logic [47:0] FOU_LOW;
    logic [5:0]  Ativo_UP;

    int n_checks = 0;
    int n_err    = 0;
    logic [47:0] hold_up = '0;

    fou_it2_tdm_fuzzifier #(.W(8), .N_IN(2), .N_MF(3)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Input_flat     (Input_flat),
        .EN_Entrada_FOU (EN_Entrada_FOU),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .busy           (busy),
        .done           (done),
        .FOU_UP         (FOU_UP),
        .FOU_LOW        (FOU_LOW),
        .Ativo_UP       (Ativo_UP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_corner(input logic [3:0] k, input logic [1:0] c, input logic [7:0] v);
        @(negedge CLK);
        cfg_we   = 1'b1;
        cfg_addr = {k, c};
        cfg_data = v;
        @(negedge CLK);
        cfg_we   = 1'b0;
    endtask

    task automatic set_trap(input logic [3:0] k, input logic [7:0] a, b, c, d);
        write_corner(k, 2'd0, a);
        write_corner(k, 2'd1, b);
        write_corner(k, 2'd2, c);
        write_corner(k, 2'd3, d);
    endtask

    // Start one evaluation and follow it to completion, checking timing.
    task automatic run_eval(input logic [7:0] x0, input logic [7:0] x1);
        int lat;
        @(negedge CLK);
        Input_flat     = {x1, x0};
        EN_Entrada_FOU = 1'b1;
        @(negedge CLK);
        EN_Entrada_FOU = 1'b0;
        check("busy_start", busy, 1);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge CLK);
            lat++;
            if (lat == 60) check("hold_mid", FOU_UP, hold_up);
        end
        check("latency", lat, 120);
        @(negedge CLK);
        check("done_single", done, 0);
        check("busy_end", busy, 0);
    endtask

    task automatic expect_res(input string tag, input logic [47:0] up, input logic [47:0] low,
                              input logic [5:0] act);
        check({tag, "_up"}, FOU_UP, up);
        check({tag, "_low"}, FOU_LOW, low);
        check({tag, "_act"}, Ativo_UP, act);
        hold_up = up;
    endtask

    initial begin
        int dones;
        int first;
        RESET          = 1'b1;
        Input_flat     = '0;
        EN_Entrada_FOU = 1'b0;
        cfg_we         = 1'b0;
        cfg_addr       = '0;
        cfg_data       = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_up", FOU_UP, 0);
        check("rst_low", FOU_LOW, 0);
        check("rst_act", Ativo_UP, 0);

        // All corners zero: x=0 hits the plateau, x=7 is at/after D.
        run_eval(8'd0, 8'd7);
        expect_res("zero_cfg", 48'h0000_00FF_FFFF, 48'h0000_00FF_FFFF, 6'b111000);

        set_trap(4'd2, 8'd5, 8'd77, 8'd153, 8'd222);
        set_trap(4'd3, 8'd18, 8'd77, 8'd153, 8'd209);

        run_eval(8'd41, 8'd7);
        expect_res("rise41", 48'h0000_0000_7F00, 48'h0000_0000_6300, 6'b010000);
        run_eval(8'd100, 8'd7);
        expect_res("plat100", 48'h0000_0000_FF00, 48'h0000_0000_FF00, 6'b010000);
        run_eval(8'd200, 8'd7);
        expect_res("fall200", 48'h0000_0000_5100, 48'h0000_0000_2800, 6'b010000);
        run_eval(8'd222, 8'd7);
        expect_res("edge222", 48'h0, 48'h0, 6'b000000);

        // Narrow rising edge and steep falling edge
        set_trap(4'd2, 8'd0, 8'd1, 8'd51, 8'd114);
        run_eval(8'd1, 8'd7);
        expect_res("narrow1", 48'h0000_0000_FF00, 48'h0, 6'b010000);
        run_eval(8'd113, 8'd7);
        expect_res("steep113", 48'h0000_0000_0400, 48'h0000_0000_FF00, 6'b010000);

        // Input 1, set 0, upper trapezoid (k=6)
        set_trap(4'd6, 8'd10, 8'd20, 8'd30, 8'd40);
        run_eval(8'd113, 8'd35);
        expect_res("in1", 48'h0000_7F00_0400, 48'h0000_0000_FF00, 6'b010100);

        // Start and corner write while busy must both be ignored.
        @(negedge CLK);
        Input_flat     = {8'd35, 8'd113};
        EN_Entrada_FOU = 1'b1;
        @(negedge CLK);
        EN_Entrada_FOU = 1'b0;
        dones = 0;
        first = -1;
        for (int c = 0; c < 300; c++) begin
            if (done) begin
                dones++;
                if (first < 0) first = c;
            end
            if (c == 30) begin
                EN_Entrada_FOU = 1'b1;
                cfg_we         = 1'b1;
                cfg_addr       = {4'd2, 2'd3};
                cfg_data       = 8'd255;
            end else begin
                EN_Entrada_FOU = 1'b0;
                cfg_we         = 1'b0;
            end
            @(negedge CLK);
        end
        check("busy_done_count", dones, 1);
        check("busy_done_cycle", first, 120);
        expect_res("busy_ign", 48'h0000_7F00_0400, 48'h0000_0000_FF00, 6'b010100);
        run_eval(8'd113, 8'd35);
        expect_res("busy_rerun", 48'h0000_7F00_0400, 48'h0000_0000_FF00, 6'b010100);

        // Reset in the middle of an evaluation
        @(negedge CLK);
        Input_flat     = {8'd35, 8'd113};
        EN_Entrada_FOU = 1'b1;
        @(negedge CLK);
        EN_Entrada_FOU = 1'b0;
        repeat (59) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        expect_res("mid_rst", 48'h0, 48'h0, 6'b000000);
        dones = 0;
        repeat (150) begin
            @(negedge CLK);
            if (done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        // Corners were cleared: x0=113 and x1=35 are now beyond D=0 everywhere.
        run_eval(8'd113, 8'd35);
        expect_res("post_rst", 48'h0, 48'h0, 6'b000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
